stack_mem_ctrl: RTL

Initiator side of the StackMemory SRAM interface. Accepts push/pop requests from the core, keeps the stack pointer, and sequences the StackMemory chip-enable, output-enable and write-enable strobes, address and write data. Returns popped words to the requester with a one-cycle valid pulse, and flags full, empty and illegal requests.

---
 rtl/stack_mem_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stack_mem_ctrl.sv
// Initiator side of the StackMemory SRAM interface: stack pointer, strobe sequencing and pop return.
// Optional build macro STACK_PEEK_EN adds a non-destructive peek request.
module stack_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
`ifdef STACK_PEEK_EN
    input  logic                  peek,
`endif
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  CE,
    output logic                  OE,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] stackData,
    output logic [1:0]            state_dbg
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

    // Handshake: push/pop/peek are level requests sampled on a rising edge only
    // while busy=0; pop_valid is a one-cycle pulse with no back-pressure.
    state_t state;
    logic   peek_op;
    logic   peek_req;

`ifdef STACK_PEEK_EN
    assign peek_req = peek;
`else
    assign peek_req = 1'b0;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            peek_op    <= 1'b0;
            CE         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            address    <= '0;
            input_data <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
        end else begin
            err       <= 1'b0;
            pop_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Push has priority; a simultaneous pop is silently dropped.
                    if (push) begin
                        if (full) begin
                            err <= 1'b1;
                        end else begin
                            input_data <= push_data;
                            address    <= count[ADDR_WIDTH-1:0];
                            CE         <= 1'b0;
                            WE         <= 1'b0;
                            busy       <= 1'b1;
                            state      <= WRITE;
                        end
                    end else if (pop || peek_req) begin
                        if (empty) begin
                            err <= 1'b1;
                        end else begin
                            address <= count[ADDR_WIDTH-1:0] - 1'b1;
                            CE      <= 1'b0;
                            OE      <= 1'b0;
                            busy    <= 1'b1;
                            peek_op <= ~pop;
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
                    CE <= 1'b1;
                    WE <= 1'b1;
                    if (!full) begin
                        count <= count + 1'b1;
                        full  <= (count == DEPTH_C - ONE_C);
                        empty <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                READ: begin
                    CE <= 1'b1;
                    OE <= 1'b1;
                    // A peek reads the top word but leaves the pointer alone.
                    if (!peek_op && !empty) begin
                        count <= count - 1'b1;
                        empty <= (count == ONE_C);
                        full  <= 1'b0;
                    end
                    state <= RWAIT;
                end
                RWAIT: begin
                    pop_data  <= stackData;
                    pop_valid <= 1'b1;
                    busy      <= 1'b0;
                    peek_op   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
